// File: rtl/bus_uart_device_pkg.sv
// Shared ECLair device definitions for the serial console: device window
// match value, register offsets, STATUS bit positions, frame FSM encodings
// and the half-bit helper used by the receive start-bit wait.
package bus_uart_device_pkg;

  localparam int unsigned DIV_W     = 16;
  localparam int unsigned BIT_CNT_W = 3;

  // bus_addr[23:20] value that selects this device
  localparam logic [3:0] DEV_MATCH = 4'b0111;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int unsigned ST_RX_VALID  = 0;
  localparam int unsigned ST_THR_EMPTY = 1;
  localparam int unsigned ST_TX_BUSY   = 2;
  localparam int unsigned ST_OVERRUN   = 3;
  localparam int unsigned ST_FRAME_ERR = 4;

  // Shared by the TX and RX frame FSMs
  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,
    FR_START = 2'd1,
    FR_DATA  = 2'd2,
    FR_STOP  = 2'd3
  } frame_state_e;

  // Counter preload that yields a tick after (div+1)>>1 clk (minimum 1 clk)
  function automatic logic [DIV_W-1:0] half_period(input logic [DIV_W-1:0] div);
    logic [DIV_W:0] p;
    p = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
    half_period = (p == '0) ? '0 : DIV_W'(p - (DIV_W+1)'(1));
  endfunction

endpackage

// File: rtl/bus_uart_device_baud_timer.sv
// Bit timer: loadable down-counter that ticks when it reaches zero and then
// reloads itself from div, so a new divisor is picked up at the next bit
// boundary.
// Ports: clk, reset (async, active-high), div (reload value), load (preload
// div), load_half (preload half a bit period), run (count enable),
// tick_c (combinational: last clk of the current bit).
module bus_uart_device_baud_timer
  import bus_uart_device_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic             load_half,
  input  logic             run,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  // Counter: preload, or count down and auto-reload at zero while running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (load_half) begin
      cnt <= half_period(div);
    end else if (run) begin
      if (cnt == '0) cnt <= div;
      else           cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick_c = run & (cnt == '0);

endmodule

// File: rtl/bus_uart_device.sv
// Memory-mapped 8N1 serial console on the ECLair bus.
// Ports: clk, reset (async, active-high); _cs/addr/rd/wr/data_in bus
// responder inputs; data_out/data_oe combinational read data and tristate
// enable; txd serial out (idle high); rxd serial in (asynchronous);
// irq = rx_valid | overrun | frame_err.
module bus_uart_device
  import bus_uart_device_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       _cs,
  input  logic [1:0] addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);

  logic [DIV_W-1:0] div;
  logic [7:0]       thr, rbr, status_c;
  logic             thr_full, rx_valid, overrun, frame_err;
  logic             rx_valid_d, overrun_d, frame_err_d;
  logic [7:0]       rbr_d;

  logic rd_act_c, wr_act_c, wr_prev, wr_pulse_c, rd_data_q, pop_c, thr_wr_c;

  // Bus strobes: one write per assertion, RBR pop after a DATA read ends
  assign rd_act_c   = ~_cs & rd;
  assign wr_act_c   = ~_cs & wr;
  assign wr_pulse_c = wr_act_c & ~wr_prev;
  assign pop_c      = rd_data_q & ~(rd_act_c & (addr == REG_DATA));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_prev   <= 1'b0;
      rd_data_q <= 1'b0;
    end else begin
      wr_prev   <= wr_act_c;
      rd_data_q <= rd_act_c & (addr == REG_DATA);
    end
  end

  // TX frame FSM signals
  frame_state_e         tx_state, tx_state_d;
  logic [BIT_CNT_W-1:0] tx_bit, tx_bit_d;
  logic [7:0]           tx_shift, tx_shift_d;
  logic                 txd_d, tx_xfer_c, tx_load_c, tx_tick_c, tx_run_c;

  // RX frame FSM signals
  frame_state_e         rx_state, rx_state_d;
  logic [BIT_CNT_W-1:0] rx_bit, rx_bit_d;
  logic [7:0]           rx_shift, rx_shift_d;
  logic                 rx_meta, rx_sync, rx_store_c, rx_ferr_c, rx_half_c;
  logic                 rx_tick_c, rx_run_c;

  assign tx_run_c = (tx_state != FR_IDLE);
  assign rx_run_c = (rx_state != FR_IDLE);

  // A write landing on the THR transfer clk refills THR
  assign thr_wr_c = wr_pulse_c & (addr == REG_DATA) & (~thr_full | tx_xfer_c);

  // DIV and THR registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= DIV_RESET;
      thr      <= '0;
      thr_full <= 1'b0;
    end else begin
      if (wr_pulse_c && addr == REG_DIV_LO) div[7:0]  <= data_in;
      if (wr_pulse_c && addr == REG_DIV_HI) div[15:8] <= data_in;
      if (thr_wr_c) thr <= data_in;
      thr_full <= thr_wr_c | (thr_full & ~tx_xfer_c);
    end
  end

  // Read mux
  always_comb begin
    status_c               = '0;
    status_c[ST_RX_VALID]  = rx_valid;
    status_c[ST_THR_EMPTY] = ~thr_full;
    status_c[ST_TX_BUSY]   = tx_run_c;
    status_c[ST_OVERRUN]   = overrun;
    status_c[ST_FRAME_ERR] = frame_err;
  end

  always_comb begin
    data_out = '0;
    if (rd_act_c) begin
      case (addr)
        REG_DATA:   data_out = rbr;
        REG_STATUS: data_out = status_c;
        REG_DIV_LO: data_out = div[7:0];
        default:    data_out = div[15:8];
      endcase
    end
  end

  assign data_oe = rd_act_c;

  bus_uart_device_baud_timer u_tx_timer (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .load      (tx_load_c),
    .load_half (1'b0),
    .run       (tx_run_c),
    .tick_c    (tx_tick_c)
  );

  bus_uart_device_baud_timer u_rx_timer (
    .clk       (clk),
    .reset     (reset),
    .div       (div),
    .load      (1'b0),
    .load_half (rx_half_c),
    .run       (rx_run_c),
    .tick_c    (rx_tick_c)
  );

  // TX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= FR_IDLE;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      txd      <= txd_d;
    end
  end

  // TX next state; STOP chains straight into START when THR is full
  always_comb begin
    tx_state_d = tx_state;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_xfer_c  = 1'b0;
    tx_load_c  = 1'b0;
    case (tx_state)
      FR_IDLE: begin
        if (thr_full) begin
          tx_xfer_c  = 1'b1;
          tx_load_c  = 1'b1;
          tx_shift_d = thr;
          tx_state_d = FR_START;
        end
      end
      FR_START: begin
        if (tx_tick_c) begin
          tx_bit_d   = '0;
          tx_state_d = FR_DATA;
        end
      end
      FR_DATA: begin
        if (tx_tick_c) begin
          tx_shift_d = tx_shift >> 1;
          tx_bit_d   = tx_bit + BIT_CNT_W'(1);
          if (tx_bit == BIT_CNT_W'(7)) tx_state_d = FR_STOP;
        end
      end
      FR_STOP: begin
        if (tx_tick_c) begin
          if (thr_full) begin
            tx_xfer_c  = 1'b1;
            tx_shift_d = thr;
            tx_state_d = FR_START;
          end else begin
            tx_state_d = FR_IDLE;
          end
        end
      end
      default: tx_state_d = FR_IDLE;
    endcase
    // Line level registered from the upcoming state
    case (tx_state_d)
      FR_START: txd_d = 1'b0;
      FR_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // RX synchroniser and state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= FR_IDLE;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= rxd;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  // RX next state: half-bit wait validates the start bit, then mid-bit samples
  always_comb begin
    rx_state_d = rx_state;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_store_c = 1'b0;
    rx_ferr_c  = 1'b0;
    rx_half_c  = 1'b0;
    case (rx_state)
      FR_IDLE: begin
        if (!rx_sync) begin
          rx_half_c  = 1'b1;
          rx_state_d = FR_START;
        end
      end
      FR_START: begin
        if (rx_tick_c) begin
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? FR_IDLE : FR_DATA;
        end
      end
      FR_DATA: begin
        if (rx_tick_c) begin
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          rx_bit_d   = rx_bit + BIT_CNT_W'(1);
          if (rx_bit == BIT_CNT_W'(7)) rx_state_d = FR_STOP;
        end
      end
      FR_STOP: begin
        if (rx_tick_c) begin
          rx_store_c = rx_sync;
          rx_ferr_c  = ~rx_sync;
          rx_state_d = FR_IDLE;
        end
      end
      default: rx_state_d = FR_IDLE;
    endcase
  end

  // Receive flags; a pop on the store clk is applied before the store
  always_comb begin
    rbr_d       = rbr;
    rx_valid_d  = rx_valid & ~pop_c;
    overrun_d   = overrun;
    frame_err_d = frame_err;
    if (wr_pulse_c && addr == REG_STATUS) begin
      if (data_in[ST_OVERRUN])   overrun_d   = 1'b0;
      if (data_in[ST_FRAME_ERR]) frame_err_d = 1'b0;
    end
    if (rx_store_c) begin
      if (rx_valid_d) begin
        overrun_d = 1'b1;
      end else begin
        rbr_d      = rx_shift;
        rx_valid_d = 1'b1;
      end
    end
    if (rx_ferr_c) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbr       <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      rbr       <= rbr_d;
      rx_valid  <= rx_valid_d;
      overrun   <= overrun_d;
      frame_err <= frame_err_d;
      irq       <= rx_valid_d | overrun_d | frame_err_d;
    end
  end

endmodule

// File: doc/bus_uart_device.md
Name: bus_uart_device

Overview:
- Memory-mapped serial console on the ECLair system bus. It is the responder to the CPU's bus initiator, selected by the decoded device window (bus_addr[23:20] = 4'b0111, active-low select).
- Presents four byte registers to the CPU: data, status, and a 16-bit baud divisor split low/high.
- Serialises CPU writes onto txd and deserialises rxd into a one-byte holding register, using 8N1 framing, LSB first.

Parameters:
- DIV_RESET, 16'd26: reset value of the baud divisor. Bit period = DIV + 1 clk cycles.

Ports:
- clk  in  1  system clock (clk_main domain)
- reset  in  1  asynchronous, active-high reset
- _cs  in  1  active-low device select (addr_device)
- addr  in  2  register offset, from bus_addr[1:0]
- rd  in  1  bus read strobe (ram_read)
- wr  in  1  bus write strobe (ram_write)
- data_in  in  8  bus_data as driven by the CPU
- data_out  out  8  read data; 8'h00 whenever data_oe = 0
- data_oe  out  1  enable for the bus_data tristate driver
- txd  out  1  serial transmit line, idle high
- rxd  in  1  serial receive line, asynchronous
- irq  out  1  rx_valid | overrun | frame_err

Behaviour:
- Reset values: txd = 1, data_out = 0, data_oe = 0, irq = 0, DIV = DIV_RESET. All flags clear; THR empty; both FSMs in IDLE.
- Register map:
  - 0 DATA: read returns RBR; write loads THR.
  - 1 STATUS: bit0 rx_valid, bit1 thr_empty, bit2 tx_busy, bit3 overrun, bit4 frame_err; bits 7:5 read 0. Writing 1 to bit3 or bit4 clears that flag; all other bits are read-only.
  - 2 DIV[7:0], 3 DIV[15:8]: read/write.
- Read path:
  - data_oe = ~_cs & rd, combinational.
  - data_out = selected register, combinational, while data_oe = 1.
  - Reading DATA pops RBR (clears rx_valid) on the clk after the access ends, i.e. on the deassertion of ~_cs & rd. Data stays stable for the whole read.
- Write path:
  - The write strobe is registered and edge-detected: one write per assertion of ~_cs & wr, with data captured on the first clk of the assertion.
  - Writing DATA when THR is full is ignored.
- rxd passes through a 2-flop synchroniser; this adds 2 clk of latency that is not counted below.
- Bit timer:
  - Each FSM has a down-counter reloaded with DIV at each bit boundary.
  - A DIV write mid-frame takes effect at the next reload.
  - DIV = 0 gives 1 clk per bit and is legal.
- TX FSM (IDLE -> START -> DATA x8 -> STOP -> IDLE):
  - In IDLE with THR full: move THR to the shifter and set thr_empty = 1, then enter START on the next clk.
  - txd drives 0 in START, data bits LSB first in DATA, 1 in STOP. Each state lasts DIV+1 clk.
  - tx_busy = 1 whenever the FSM is not in IDLE.
  - If THR is refilled during a frame, the next frame follows STOP with no idle gap.
  - A CPU write on the same clk as the THR transfer is accepted and refills THR.
- RX FSM (IDLE -> START -> DATA x8 -> STOP -> IDLE):
  - IDLE: a synchronised 0 enters START.
  - START: wait (DIV+1)>>1 clk, then resample. If the line reads 1 it was a false start; return to IDLE with no flag set.
  - DATA: sample every DIV+1 clk.
  - STOP sample = 1: store the byte to RBR and set rx_valid. If rx_valid was already set, set overrun and discard the new byte; the old byte is kept.
  - STOP sample = 0: set frame_err and discard the byte.
  - If a pop and a store land on the same clk, the pop is applied first, so the new byte is stored, rx_valid stays 1 and overrun is not set.
- Reset mid-frame aborts both FSMs immediately: txd = 1 and the partial RX byte is lost.
- All state and outputs are synchronous to clk; no logic runs on bus strobes as clocks.

Decomposition:
- Shared include eclair_dev_defs: device window match value 4'b0111, register offsets, STATUS bit positions, TX/RX state encodings.
- One sub-module, baud_timer: loadable down-counter with reload value DIV, a half-period start option, and a tick output. It is instantiated twice, once for TX and once for RX.

Test Plan:
- Reset check: assert reset asynchronously mid-clock. txd = 1 immediately, STATUS reads 8'h02, DIV reads 26 (offset 2 = 8'h1A, offset 3 = 8'h00), irq = 0.
- TX: write DIV = 3, then write DATA = 8'hA5. txd = 0 for 4 clk, then bits 1,0,1,0,0,1,0,1 at 4 clk each, then 1 for 4 clk. tx_busy is high for 40 clk, and thr_empty = 1 from 1 clk after the write.
- Back-to-back TX: write 8'h01, then write 8'h80 while the first frame is busy. The two frames are contiguous, 80 clk total. A third write while THR is full is ignored.
- RX: with DIV = 3, drive the frame for 8'h3C on rxd. rx_valid = 1 and irq = 1; reading DATA returns 8'h3C, and rx_valid = 0 after the read ends.
- RX errors:
  - Drive 8'h11 then 8'h22 without reading: DATA = 8'h11 and overrun = 1.
  - Drive a frame with stop bit = 0: frame_err = 1 and rx_valid is unchanged.
  - Write STATUS = 8'h18: both flags clear.
- Glitch and decode: a 1-clk low pulse on rxd is a false start, and no flag is set. Any access with _cs = 1 gives data_oe = 0 and no register change.
